// File: rtl/cadence_pkg.sv
// cadence_pkg: constants and state encoding shared by the metronome and the tempo detector.
package cadence_pkg;
    localparam int unsigned CLK_FREQ_DEF = 50_000_000;
    localparam int BPM_W = 9;
    localparam logic [BPM_W-1:0] BPM_MAX = 9'd511;
    typedef enum logic [1:0] {IDLE, ARMED, DIVIDE} state_t;
endpackage

// File: rtl/udiv32.sv
// udiv32: restoring unsigned 32/32 divider, one quotient bit per clock, done 32 cycles after start.
module udiv32 (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] dividend,
    input  logic [31:0] divisor,
    output logic [31:0] quotient,
    output logic        done
);
    logic [31:0] r_rem, r_q, r_d;
    logic [5:0]  r_k;
    logic        r_done;
    logic [32:0] w_sh;
    logic        w_ge;
    logic [31:0] w_rem_nx;
    // The partial remainder stays below the divisor, so the restored value fits in 32 bits.
    assign w_sh     = {r_rem, r_q[31]};
    assign w_ge     = w_sh >= {1'b0, r_d};
    assign w_rem_nx = w_ge ? 32'(w_sh - {1'b0, r_d}) : w_sh[31:0];
    assign quotient = r_q;
    assign done     = r_done;
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rem  <= '0;
            r_q    <= '0;
            r_d    <= '0;
            r_k    <= '0;
            r_done <= 1'b0;
        end else if (start) begin
            r_rem  <= '0;
            r_q    <= dividend;
            r_d    <= divisor;
            r_k    <= 6'd32;
            r_done <= 1'b0;
        end else if (r_k != 6'd0) begin
            r_rem  <= w_rem_nx;
            r_q    <= {r_q[30:0], w_ge};
            r_k    <= r_k - 6'd1;
            r_done <= r_k == 6'd1;
        end else begin
            r_done <= 1'b0;
        end
    end
endmodule

// File: rtl/tempo_detector.sv
// tempo_detector: drains the codec input FIFO, detects amplitude onsets and reports the
// inter-onset tempo in bpm via a sequential divider.
module tempo_detector
    import cadence_pkg::*;
#(
    parameter int unsigned CLK_FREQ       = CLK_FREQ_DEF,
    parameter logic [31:0] THRESHOLD      = 32'd100_000_000,
    parameter int unsigned HOLDOFF_CYCLES = 5_000_000
) (
    input  logic             CLOCK_50,
    input  logic             reset,
    input  logic             enable,
    input  logic             audio_in_available,
    input  logic [31:0]      left_channel_audio_in,
    output logic             read_audio_in,
    output logic             onset,
    output logic [BPM_W-1:0] bpm,
    output logic             bpm_valid
);
    localparam logic [63:0] DIV_WIDE = 64'(CLK_FREQ) * 64'd60;
    localparam logic [31:0] DIVIDEND = DIV_WIDE[31:0];
    localparam logic [31:0] HOLD     = 32'(HOLDOFF_CYCLES);

    state_t           r_state, w_next;
    logic [31:0]      r_sample, r_holdoff, r_cnt;
    logic             r_sample_vld, r_onset, r_bpm_valid;
    logic [BPM_W-1:0] r_bpm;
    logic [31:0]      w_mag, w_q;
    logic             w_hit, w_start, w_done, w_upd;
    logic [BPM_W-1:0] w_bpm;

    assign read_audio_in = enable & audio_in_available;
    assign onset         = r_onset;
    assign bpm           = r_bpm;
    assign bpm_valid     = r_bpm_valid;

    assign w_mag = !r_sample[31] ? r_sample : (r_sample == 32'h8000_0000 ? 32'h7FFF_FFFF : -r_sample);
    assign w_hit = enable && r_sample_vld && (w_mag > THRESHOLD) && (r_holdoff == 32'd0);
    assign w_upd = enable && (r_state == DIVIDE) && w_done;
    assign w_bpm = (w_q > 32'(BPM_MAX)) ? BPM_MAX : w_q[BPM_W-1:0];

    // Interval is clocks between onset edges; the counter holds interval-1 at the capturing edge.
    udiv32 u_div (
        .clk      (CLOCK_50),
        .rst      (reset),
        .start    (w_start),
        .dividend (DIVIDEND),
        .divisor  (r_cnt + 32'd1),
        .quotient (w_q),
        .done     (w_done)
    );

    always_comb begin
        w_next  = r_state;
        w_start = 1'b0;
        if (!enable) begin
            w_next = IDLE;
        end else begin
            case (r_state)
                IDLE:    w_next = w_hit ? ARMED : IDLE;
                ARMED: begin
                    w_start = w_hit;
                    w_next  = w_hit ? DIVIDE : (r_cnt == DIVIDEND - 32'd1) ? IDLE : ARMED;
                end
                DIVIDE:  w_next = w_done ? ARMED : DIVIDE;
                default: w_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            r_state      <= IDLE;
            r_sample     <= '0;
            r_sample_vld <= 1'b0;
            r_onset      <= 1'b0;
            r_holdoff    <= '0;
            r_cnt        <= '0;
            r_bpm        <= '0;
            r_bpm_valid  <= 1'b0;
        end else begin
            r_state      <= w_next;
            r_sample     <= left_channel_audio_in;
            r_sample_vld <= read_audio_in;
            r_onset      <= w_hit;
            r_holdoff    <= !enable ? 32'd0 : w_hit ? HOLD : (r_holdoff != 32'd0) ? r_holdoff - 32'd1 : 32'd0;
            r_cnt        <= (w_hit && r_state != DIVIDE) ? 32'd0 : r_cnt + 32'd1;
            r_bpm        <= w_upd ? w_bpm : r_bpm;
            r_bpm_valid  <= w_upd;
        end
    end
endmodule
